mdu_sequencer: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Replaces the single-cycle combinational MULT/DIV path in the ALU.
- Sequences a shared shift/add-subtract datapath over 32 iterations.
- Raises BUSY so the pipeline stalls MFHI/MFLO and further MULT/DIV until the result is committed.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_divstep.sv | 26 ++
 rtl/mdu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module mdu_divstep
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below the divisor, so on the no-subtract
    // path the shifted value still fits in WIDTH bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, div_i};
        q_o     = (shifted >= {1'b0, div_i});
        rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MIPS multiply/divide unit with HI/LO; shared shift/add-subtract datapath.
// Optional MDU_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic             MT_HI,
    input  logic             MT_LO,
    input  logic             ABORT,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int AW    = 2 * WIDTH;

    mdu_state_t       state_q;
    mdu_op_t          op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] opnd_q;
    logic [AW-1:0]    acc_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    mdu_op_t          op_in;
    logic             in_div;
    logic             in_div_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        op_in       = mdu_op_t'(OP);
        in_div      = op_is_div(op_in);
        in_div_zero = in_div && (IN_B == '0);
        a_neg       = op_is_signed(op_in) && IN_A[WIDTH-1];
        b_neg       = op_is_signed(op_in) && IN_B[WIDTH-1];
        a_mag       = a_neg ? -IN_A : IN_A;
        b_mag       = b_neg ? -IN_B : IN_B;
    end

    logic [WIDTH-1:0] div_rem;
    logic             div_qbit;

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i (acc_q[AW-1:WIDTH]),
        .div_i (opnd_q),
        .bit_i (acc_q[WIDTH-1]),
        .rem_o (div_rem),
        .q_o   (div_qbit)
    );

    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_acc_d;
    logic [AW-1:0]    step_acc_d;
    logic [AW-1:0]    early_acc_d;
    logic             early_out;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] hi_fix_d;
    logic [WIDTH-1:0] lo_fix_d;

`ifdef MDU_EARLY_OUT_EN
    logic [AW-1:0] rem_mask;
`endif

    // Multiply: acc = {partial product, unconsumed multiplier}; add the
    // multiplicand when the multiplier LSB is set, then shift right.
    always_comb begin
        mul_sum    = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
        step_acc_d = op_is_div(op_q) ? {div_rem, acc_q[WIDTH-2:0], div_qbit} : mul_acc_d;
`ifdef MDU_EARLY_OUT_EN
        // cnt_q low bits of the stepped accumulator are still multiplier bits;
        // if all zero, the rest of the run is pure shifting.
        rem_mask    = (AW'(1) << cnt_q) - AW'(1);
        early_out   = !op_is_div(op_q) && ((mul_acc_d & rem_mask) == '0);
        early_acc_d = mul_acc_d >> cnt_q;
`else
        early_out   = 1'b0;
        early_acc_d = mul_acc_d;
`endif
    end

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
        hi_fix_d = op_is_div(op_q) ? rem_fix : prod_fix[AW-1:WIDTH];
        lo_fix_d = op_is_div(op_q) ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // NOTE: every register here uses <= so all of them see the pre-edge values;
    // a blocking write would let later statements observe the new state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            if (ABORT) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (MT_HI) hi_q <= IN_A;
                        if (MT_LO) lo_q <= IN_A;
                        if (!START) begin
                            state_q <= ST_IDLE;
                        end else if (in_div_zero) begin
                            op_q    <= op_in;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                        end else begin
                            op_q      <= op_in;
                            state_q   <= ST_RUN;
                            busy_q    <= 1'b1;
                            cnt_q     <= CNT_W'(WIDTH - 1);
                            opnd_q    <= in_div ? b_mag : a_mag;
                            acc_q     <= {WIDTH'(0), (in_div ? a_mag : b_mag)};
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= in_div && a_neg;
                        end
                    end
                    ST_RUN: begin
                        acc_q <= early_out ? early_acc_d : step_acc_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0 || early_out) state_q <= ST_FIX;
                    end
                    ST_FIX: begin
                        hi_q    <= hi_fix_d;
                        lo_q    <= lo_fix_d;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign DIV_ZERO = dz_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random ops
// against an arithmetic reference model of HI/LO and DONE latency.
module tb_mdu_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [31:0] IN_A = '0;
    logic [31:0] IN_B = '0;
    logic        MT_HI = 1'b0;
    logic        MT_LO = 1'b0;
    logic        ABORT = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        DIV_ZERO;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mdu_sequencer dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .OP       (OP),
        .IN_A     (IN_A),
        .IN_B     (IN_B),
        .MT_HI    (MT_HI),
        .MT_LO    (MT_LO),
        .ABORT    (ABORT),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DIV_ZERO (DIV_ZERO),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference result from plain integer arithmetic.
    task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = model_hi;
        lo = model_lo;
        case (op)
            2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'b10: begin
                if (b == 0) dz = 1'b1;
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 0) dz = 1'b1;
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        int lat;
        lat = 34;
        if (op[1] && b == 0) lat = 1;
`ifdef MDU_EARLY_OUT_EN
        if (!op[1]) begin
            logic [31:0] m;
            int h;
            m = (!op[0] && b[31]) ? -b : b;
            h = 0;
            for (int i = 0; i < 32; i++) if (m[i]) h = i;
            lat = h + 3;
        end
`endif
        return lat;
    endfunction

    // Entered with inputs idle, #1 after an edge; returns #1 into the DONE cycle
    // (or the timeout cycle). disturb pokes START/MT_HI mid-run; mt_lo pairs MT_LO with START.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb, input bit mt_lo);
        logic [31:0] eh, el;
        logic        edz;
        int          lat, done_cyc, busy_bad;
        ref_model(op, a, b, eh, el, edz);
        lat = ref_latency(op, b);
        START = 1'b1; OP = op; IN_A = a; IN_B = b; MT_LO = mt_lo;
        tick();
        START = 1'b0; MT_LO = 1'b0;
        if (mt_lo) begin
            check({tag, "_mtlo_with_start"}, 64'(LO), 64'(a));
            if (edz) el = a;
        end
        done_cyc = 0;
        busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) tick();
            if (DONE) begin done_cyc = c; break; end
            if (BUSY !== (c < lat)) busy_bad++;
            if (disturb && c == 5) begin
                START = 1'b1; MT_HI = 1'b1; OP = 2'b01; IN_A = $urandom; IN_B = $urandom;
            end
            if (disturb && c == 6) begin
                START = 1'b0; MT_HI = 1'b0;
            end
        end
        check({tag, "_latency"}, 64'(done_cyc), 64'(lat));
        check({tag, "_busy"}, 64'(busy_bad), 64'd0);
        check({tag, "_hi"}, 64'(HI), 64'(eh));
        check({tag, "_lo"}, 64'(LO), 64'(el));
        check({tag, "_divzero"}, 64'(DIV_ZERO), 64'(edz));
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
        MT_HI = 1'b1; IN_A = hv; tick(); MT_HI = 1'b0;
        MT_LO = 1'b1; IN_A = lv; tick(); MT_LO = 1'b0;
        model_hi = hv;
        model_lo = lv;
        check("mt_hi", 64'(HI), 64'(hv));
        check("mt_lo", 64'(LO), 64'(lv));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(BUSY), 64'd0);
        check({tag, "_done"}, 64'(DONE), 64'd0);
        check({tag, "_hi"}, 64'(HI), 64'(model_hi));
        check({tag, "_lo"}, 64'(LO), 64'(model_lo));
    endtask

    initial begin
        int done_seen;
        #2;
        check("rst_outputs", {BUSY, DONE, DIV_ZERO, HI, LO}, '0);
        @(negedge CLK); RST_N = 1'b1;
        tick();

        do_op("multu_ff_x2", 2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0);
        check("multu_ff_x2_hi_abs", 64'(HI), 64'h1);
        tick();
        do_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);
        check("mult_m3x5_lo_abs", 64'(LO), 64'hFFFF_FFF1);
        tick();
        do_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_m7d2_abs", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        // Back-to-back: START during the DONE cycle.
        do_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_min_m1_abs", {HI, LO}, 64'h0000_0000_8000_0000);
        tick();

        mt_write(32'h11, 32'h22);
        do_op("divu_by0", 2'b11, 32'd100, 32'd0, 0, 0);
        check("divu_by0_keep", {HI, LO}, 64'h0000_0011_0000_0022);
        tick();
        check("after_done_pulse", 64'(DONE), 64'd0);

        // MT_LO with START, then START/MT_HI while busy.
        do_op("mtlo_start", 2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1, 1);
        // ABORT in the DONE cycle keeps the committed result.
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        check_idle("abort_in_done");

        // MULTU 7*9 aborted in cycle 10.
        START = 1'b1; OP = 2'b01; IN_A = 32'd7; IN_B = 32'd9;
        tick();
        START = 1'b0;
        repeat (9) tick();
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        check_idle("abort_c11");
        done_seen = 0;
        repeat (30) begin tick(); if (DONE) done_seen++; end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check_idle("abort_late");

        // Same operation, reset asserted in cycle 10.
        START = 1'b1; OP = 2'b01; IN_A = 32'd7; IN_B = 32'd9;
        tick();
        START = 1'b0;
        repeat (9) tick();
        RST_N = 1'b0;
        #1;
        check("rst_mid_op", {BUSY, DONE, DIV_ZERO, HI, LO}, '0);
        model_hi = '0;
        model_lo = '0;
        @(negedge CLK); RST_N = 1'b1;
        tick();
        do_op("post_rst_multu", 2'b01, 32'd7, 32'd9, 0, 0);
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = 32'h1 << $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            do_op($sformatf("rand%0d", i), op, a, b,
                  (ref_latency(op, b) > 8) && ($urandom_range(0, 3) == 0), 0);
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
